// File: rtl/core_mem_arb_pkg.sv
// rtl/core_mem_arb_pkg.sv - shared types and helpers for the N-input core memory arbiter
package core_mem_arb_pkg;

  localparam int PKT_W_DEFAULT = 128;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Tag holds an input index; never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/core_rr_arbiter.sv
// rtl/core_rr_arbiter.sv - fixed-priority / round-robin one-hot arbiter
module core_rr_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int TW         = tag_w(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  arb_mode_e             mode,
  input  logic [TW-1:0]         rr_ptr,
  output logic [NUM_INPUTS-1:0] grant,
  output logic [TW-1:0]         grant_idx,
  output logic                  grant_any
);

  int cand;

  // Scan starts at 0 for fixed priority, at rr_ptr (wrapping) for round-robin.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand = (mode == ARB_RR) ? ((int'(rr_ptr) + i) % NUM_INPUTS) : i;
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = TW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_memory_arbiter_n.sv
// rtl/core_memory_arbiter_n.sv - merges N requester streams onto one memory bus,
// routing in-order responses back through a tag FIFO
module core_memory_arbiter_n
  import core_mem_arb_pkg::*;
#(
  parameter int NUM_INPUTS      = 2,
  parameter int PKT_W           = PKT_W_DEFAULT,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_INPUTS-1:0]                 in_req_valid,
  output logic [NUM_INPUTS-1:0]                 in_req_ready,
  input  logic [NUM_INPUTS*PKT_W-1:0]           in_req_pkt,
  output logic [NUM_INPUTS-1:0]                 in_rsp_valid,
  input  logic [NUM_INPUTS-1:0]                 in_rsp_ready,
  output logic [PKT_W-1:0]                      in_rsp_pkt,
  output logic                                  out_req_valid,
  input  logic                                  out_req_ready,
  output logic [PKT_W-1:0]                      out_req_pkt,
  input  logic                                  out_rsp_valid,
  output logic                                  out_rsp_ready,
  input  logic [PKT_W-1:0]                      out_rsp_pkt,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding,
  output logic                                  err_unexp_rsp
);

  localparam int TW = tag_w(NUM_INPUTS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  logic [TW-1:0]         rr_ptr;
  logic [TW-1:0]         grant_idx;
  logic [TW-1:0]         head;
  logic [NUM_INPUTS-1:0] grant;
  logic                  grant_any;
  logic                  can_grant;
  logic                  grant_fire;
  logic                  rsp_fire;
  logic                  empty;
  logic [PKT_W-1:0]      win_pkt;
  logic [TW-1:0]         tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  core_rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .TW         (TW)
  ) u_arb (
    .req       (in_req_valid),
    .mode      (MODE),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The tag FIFO holds exactly the outstanding requests, so its occupancy is the counter.
  assign empty        = (outstanding == '0);
  assign can_grant    = (!out_req_valid || out_req_ready) && (outstanding < CW'(MAX_OUTSTANDING));
  assign grant_fire   = can_grant && grant_any;
  assign in_req_ready = grant_fire ? grant : '0;
  assign head         = tag_mem[rd_ptr];
  assign in_rsp_pkt   = out_rsp_pkt;
  assign rsp_fire     = out_rsp_valid && out_rsp_ready;

  always_comb begin
    win_pkt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx == TW'(i)) win_pkt = in_req_pkt[i*PKT_W +: PKT_W];
    end
  end

  always_comb begin
    in_rsp_valid  = '0;
    out_rsp_ready = 1'b0;
    if (!empty) begin
      in_rsp_valid[head] = out_rsp_valid;
      out_rsp_ready      = in_rsp_ready[head];
    end
  end

  always_ff @(posedge clk) begin
    if (grant_fire) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_req_valid <= 1'b0;
      out_req_pkt   <= '0;
      outstanding   <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      rr_ptr        <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      if (grant_fire) begin
        out_req_valid <= 1'b1;
        out_req_pkt   <= win_pkt;
        wr_ptr        <= ptr_inc(wr_ptr);
        rr_ptr        <= (grant_idx == TW'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
      end else if (out_req_ready) begin
        out_req_valid <= 1'b0;
      end
      if (rsp_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({grant_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (out_rsp_valid && empty) err_unexp_rsp <= 1'b1;
    end
  end

endmodule
